// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file: default sizes, FSM state, clog2 helper.
package rf_pkg;

  localparam int unsigned RF_XLEN  = 32;
  localparam int unsigned RF_NREGS = 32;

  typedef enum logic {
    RF_INIT,
    RF_RUN
  } rf_state_e;

  function automatic int unsigned rf_clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write bits: writes clear, issue sets (set wins), registered OR output.
// With RF_BYPASS_EN defined, read-side pend bits see same-cycle write clears.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned NREGS    = RF_NREGS,
  parameter int unsigned NRD      = 2,
  parameter int unsigned NWR      = 2,
  parameter int unsigned AW       = rf_clog2(NREGS),
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_run,
  input  logic [NWR-1:0]    i_wr_act,
  input  logic [NWR*AW-1:0] i_wr_addr,
  input  logic              i_iss_en,
  input  logic [AW-1:0]     i_iss_addr,
  input  logic [NRD*AW-1:0] i_rd_addr,
  output logic [NRD-1:0]    o_rd_pend,
  output logic              o_pend_any
);

  logic [NREGS-1:0] r_pend;
  logic [NREGS-1:0] w_pend_d;
  logic             r_pend_any;
  logic             w_iss_act;

  assign w_iss_act = i_run && i_iss_en && !((ZERO_REG != 0) && (i_iss_addr == '0));

  // Clears first, then the set, so a new producer supersedes the retiring one.
  always_comb begin
    w_pend_d = r_pend;
    for (int p = 0; p < NWR; p++) begin
      if (i_wr_act[p]) w_pend_d[i_wr_addr[p*AW +: AW]] = 1'b0;
    end
    if (w_iss_act) w_pend_d[i_iss_addr] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_pend     <= '0;
      r_pend_any <= 1'b0;
    end else begin
      r_pend     <= w_pend_d;
      r_pend_any <= |r_pend;
    end
  end

  always_comb begin
    o_rd_pend = '0;
    for (int k = 0; k < NRD; k++) begin
      o_rd_pend[k] = r_pend[i_rd_addr[k*AW +: AW]];
`ifdef RF_BYPASS_EN
      for (int p = 0; p < NWR; p++) begin
        if (i_wr_act[p] && (i_wr_addr[p*AW +: AW] == i_rd_addr[k*AW +: AW]) &&
            !(w_iss_act && (i_iss_addr == i_rd_addr[k*AW +: AW]))) begin
          o_rd_pend[k] = 1'b0;
        end
      end
`endif
    end
  end

  assign o_pend_any = r_pend_any;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with post-reset clear sequencer and pending-write scoreboard.
// Define RF_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_mp
  import rf_pkg::*;
#(
  parameter int unsigned XLEN     = RF_XLEN,
  parameter int unsigned NREGS    = RF_NREGS,
  parameter int unsigned NRD      = 2,
  parameter int unsigned NWR      = 2,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned AW      = rf_clog2(NREGS)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  output logic                o_init_busy,
  input  logic [NRD*AW-1:0]   i_rd_addr,
  output logic [NRD*XLEN-1:0] o_rd_data,
  output logic [NRD-1:0]      o_rd_pend,
  input  logic [NWR-1:0]      i_wr_en,
  input  logic [NWR*AW-1:0]   i_wr_addr,
  input  logic [NWR*XLEN-1:0] i_wr_data,
  input  logic                i_iss_en,
  input  logic [AW-1:0]       i_iss_addr,
  output logic                o_pend_any
);

  rf_state_e         r_state;
  logic [AW-1:0]     r_idx;
  logic [XLEN-1:0]   r_regs [NREGS];
  logic              w_run;
  logic [NWR-1:0]    w_wr_act;

  assign w_run       = (r_state == RF_RUN);
  assign o_init_busy = (r_state == RF_INIT);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= RF_INIT;
      r_idx   <= '0;
    end else if (r_state == RF_INIT) begin
      if (r_idx == AW'(NREGS - 1)) r_state <= RF_RUN;
      else                         r_idx   <= r_idx + 1'b1;
    end
  end

  always_comb begin
    w_wr_act = '0;
    for (int p = 0; p < NWR; p++) begin
      w_wr_act[p] = w_run && i_wr_en[p] &&
                    !((ZERO_REG != 0) && (i_wr_addr[p*AW +: AW] == '0));
    end
  end

  // No reset on the array; later ports overwrite earlier ones on a shared address.
  always_ff @(posedge i_clk) begin
    if (r_state == RF_INIT) begin
      r_regs[r_idx] <= '0;
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (w_wr_act[p]) r_regs[i_wr_addr[p*AW +: AW]] <= i_wr_data[p*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    o_rd_data = '0;
    for (int k = 0; k < NRD; k++) begin
      if (w_run) begin
        o_rd_data[k*XLEN +: XLEN] = r_regs[i_rd_addr[k*AW +: AW]];
`ifdef RF_BYPASS_EN
        for (int p = 0; p < NWR; p++) begin
          if (w_wr_act[p] && (i_wr_addr[p*AW +: AW] == i_rd_addr[k*AW +: AW])) begin
            o_rd_data[k*XLEN +: XLEN] = i_wr_data[p*XLEN +: XLEN];
          end
        end
`endif
        if ((ZERO_REG != 0) && (i_rd_addr[k*AW +: AW] == '0)) o_rd_data[k*XLEN +: XLEN] = '0;
      end
    end
  end

  rf_scoreboard #(
    .NREGS    (NREGS),
    .NRD      (NRD),
    .NWR      (NWR),
    .AW       (AW),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_run      (w_run),
    .i_wr_act   (w_wr_act),
    .i_wr_addr  (i_wr_addr),
    .i_iss_en   (i_iss_en),
    .i_iss_addr (i_iss_addr),
    .i_rd_addr  (i_rd_addr),
    .o_rd_pend  (o_rd_pend),
    .o_pend_any (o_pend_any)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp with default parameters (32x32, 2 read, 2 write ports).
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_busy;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_pend;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic        pend_any;

  regfile_mp u_dut (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .o_init_busy (init_busy),
    .i_rd_addr   (rd_addr),
    .o_rd_data   (rd_data),
    .o_rd_pend   (rd_pend),
    .i_wr_en     (wr_en),
    .i_wr_addr   (wr_addr),
    .i_wr_data   (wr_data),
    .i_iss_en    (iss_en),
    .i_iss_addr  (iss_addr),
    .o_pend_any  (pend_any)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  typedef struct {
    bit        we0;
    bit [4:0]  wa0;
    bit [31:0] wd0;
    bit        we1;
    bit [4:0]  wa1;
    bit [31:0] wd1;
    bit        iss;
    bit [4:0]  ia;
    bit [4:0]  ra0;
    bit [4:0]  ra1;
    bit [31:0] e0;
    bit [31:0] e1;
    bit        ep0;
    bit        ep1;
    bit        epa;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[15];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic push(input string nm, input logic [31:0] v);
    exp_t e;
    e.name = nm;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic chk(input logic [31:0] act);
    exp_t e;
    n_chk++;
    if (exp_q.size() == 0) begin
      $display("FAIL scoreboard_empty: got %h, nothing expected", act);
    end else begin
      e = exp_q.pop_front();
      if (act === e.val) n_pass++;
      else $display("FAIL %s: got %h want %h", e.name, act, e.val);
    end
  endtask

  task automatic drive(input bit we0, input bit [4:0] wa0, input bit [31:0] wd0,
                       input bit we1, input bit [4:0] wa1, input bit [31:0] wd1,
                       input bit iss, input bit [4:0] ia, input bit [4:0] ra0,
                       input bit [4:0] ra1);
    wr_en    = {we1, we0};
    wr_addr  = {wa1, wa0};
    wr_data  = {wd1, wd0};
    iss_en   = iss;
    iss_addr = ia;
    rd_addr  = {ra1, ra0};
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until init_busy falls, bounded.
  task automatic count_init(input string nm);
    int n;
    n = 0;
    push(nm, 32'd32);
    while (init_busy && n < 100) begin
      tick();
      n++;
    end
    chk(32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b1, 5'd1, 32'd10, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd2, 5'd5,
                 32'd0, 32'd0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'd20, 1'b0, 5'd0, 5'd1, 5'd0,
                 32'd10, 32'd0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 5'd1, 32'd15, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd2,
                 32'd0, 32'd0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, 1'b0, 5'd0, 5'd1, 5'd0,
                 32'd15, 32'd0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 5'd3, 5'd2,
                 32'h22, 32'd0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd4, 5'd4,
                 32'd0, 32'd0, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'd25, 1'b0, 5'd0, 5'd3, 5'd2,
                 32'h22, 32'd0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd4, 5'd1,
                 32'd25, 32'd15, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 5'd4, 32'd30, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 5'd1, 5'd2,
                 32'd15, 32'd0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd4, 5'd3,
                 32'd30, 32'h22, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd4,
                 32'd0, 32'd30, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'd40, 1'b0, 5'd0, 5'd0, 5'd2,
                 32'd0, 32'd0, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd4, 5'd6,
                 32'd40, 32'd0, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd4, 5'd1,
                 32'd40, 32'd15, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd2,
                 32'h22, 32'd0, 1'b0, 1'b0, 1'b0};

    // Reset, then clear sequence with writes/issues attempted during INIT
    rst_n = 1'b0;
    idle();
    #1;
    push("reset_init_busy", 32'd1);
    push("reset_pend_any", 32'd0);
    push("reset_rd_pend", 32'd0);
    chk(32'(init_busy));
    chk(32'(pend_any));
    chk(32'(rd_pend));
    tick();
    tick();
    rst_n = 1'b1;
    drive(1'b1, 5'd5, 32'hDEAD, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd5, 5'd7);
    #2;
    push("init_rd_data", 32'd0);
    chk(rd_data[31:0]);
    count_init("init_cycles");
    idle();
    rd_addr = {5'd7, 5'd5};
    #2;
    push("post_init_x5", 32'd0);
    push("post_init_pend_x7", 32'd0);
    push("post_init_pend_any", 32'd0);
    chk(rd_data[31:0]);
    chk(32'(rd_pend[1]));
    chk(32'(pend_any));
    tick();

    // Table of single-cycle transactions
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].we0, vecs[i].wa0, vecs[i].wd0, vecs[i].we1, vecs[i].wa1, vecs[i].wd1,
            vecs[i].iss, vecs[i].ia, vecs[i].ra0, vecs[i].ra1);
      push($sformatf("vec%0d_rd0", i), vecs[i].e0);
      push($sformatf("vec%0d_rd1", i), vecs[i].e1);
      push($sformatf("vec%0d_pend0", i), 32'(vecs[i].ep0));
      push($sformatf("vec%0d_pend1", i), 32'(vecs[i].ep1));
      push($sformatf("vec%0d_pend_any", i), 32'(vecs[i].epa));
      #2;
      chk(rd_data[31:0]);
      chk(rd_data[63:32]);
      chk(32'(rd_pend[0]));
      chk(32'(rd_pend[1]));
      chk(32'(pend_any));
      tick();
    end

    // Same-cycle write and read of x6
    drive(1'b1, 5'd6, 32'h5A, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd6, 5'd0);
`ifdef RF_BYPASS_EN
    push("bypass_same_cycle", 32'h5A);
`else
    push("bypass_same_cycle", 32'd0);
`endif
    #2;
    chk(rd_data[31:0]);
    tick();
    drive(1'b1, 5'd6, 32'd1, 1'b1, 5'd6, 32'd2, 1'b0, 5'd0, 5'd6, 5'd0);
`ifdef RF_BYPASS_EN
    push("bypass_priority", 32'd2);
`else
    push("bypass_priority", 32'h5A);
`endif
    #2;
    chk(rd_data[31:0]);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 5'd6, 5'd0);
    push("bypass_next_cycle", 32'd2);
    #2;
    chk(rd_data[31:0]);
    tick();
    drive(1'b1, 5'd6, 32'd3, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd6, 5'd0);
`ifdef RF_BYPASS_EN
    push("bypass_pend_clear", 32'd0);
`else
    push("bypass_pend_clear", 32'd1);
`endif
    #2;
    chk(32'(rd_pend[0]));
    tick();
    idle();
    rd_addr = {5'd0, 5'd6};
    #2;
    push("pend_after_write", 32'd0);
    push("x6_after_write", 32'd3);
    chk(32'(rd_pend[0]));
    chk(rd_data[31:0]);
    tick();

    // Reset in RUN with a pending bit set
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd0);
    tick();
    iss_en = 1'b0;
    tick();
    push("run_pend_x9", 32'd1);
    push("run_pend_any", 32'd1);
    chk(32'(rd_pend[0]));
    chk(32'(pend_any));
    #1;
    rst_n = 1'b0;
    #1;
    push("run_rst_busy", 32'd1);
    push("run_rst_pend_any", 32'd0);
    push("run_rst_rd_pend", 32'd0);
    chk(32'(init_busy));
    chk(32'(pend_any));
    chk(32'(rd_pend[0]));
    tick();
    rst_n = 1'b1;
    count_init("run_rst_init_cycles");

    // Reset again around clear index 10
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    push("mid_init_busy_before", 32'd1);
    chk(32'(init_busy));
    #2;
    rst_n = 1'b0;
    #1;
    push("mid_init_rst_busy", 32'd1);
    push("mid_init_rst_pend_any", 32'd0);
    chk(32'(init_busy));
    chk(32'(pend_any));
    #2;
    rst_n = 1'b1;
    count_init("mid_init_cycles");
    rd_addr = {5'd3, 5'd1};
    #2;
    push("cleared_x1", 32'd0);
    push("cleared_x3", 32'd0);
    chk(rd_data[31:0]);
    chk(rd_data[63:32]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file with a per-register pending-write scoreboard. Successor to the single-issue CPU register file.
- Sits in exec_unit, replacing the current rf instance.
- Adds configurable width, depth and port counts, multiple write ports with a defined priority, and a sequential post-reset clear sequencer.
- Supports the dual-issue and pipelined datapath work.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers; power of two, at least 2.
- NRD, 2, number of read ports.
- NWR, 2, number of write ports.
- ZERO_REG, 1, when 1 register 0 is hardwired to zero; when 0 it is an ordinary register.
- AW, derived localparam equal to clog2(NREGS), address width.

Ports:
- clk  in  1  system clock; everything is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- init_busy  out  1  high while the clear sequencer runs.
- rd_addr  in  NRD*AW  read addresses; port k occupies bits [k*AW +: AW].
- rd_data  out  NRD*XLEN  read data, packed the same way as rd_addr.
- rd_pend  out  NRD  scoreboard pending bit of each read address.
- wr_en  in  NWR  write enables.
- wr_addr  in  NWR*AW  write addresses.
- wr_data  in  NWR*XLEN  write data.
- iss_en  in  1  marks a destination register as pending.
- iss_addr  in  AW  destination register to mark pending.
- pend_any  out  1  OR of all scoreboard bits.

Behaviour:
- Reset asserted (reset=0), at any time including mid-sequence:
  - FSM goes to INIT, clear index goes to 0, all pending bits go to 0.
  - init_busy=1 immediately; pend_any=0; rd_pend=0.
- Register array contents are not reset asynchronously; this keeps the array BRAM/LUTRAM-friendly.
- FSM states: INIT and RUN.
  - INIT: from the first clk edge after reset deasserts, writes 0 to register idx once per cycle, idx = 0..NREGS-1.
  - Leaves INIT after the edge that writes NREGS-1; init_busy falls on that edge. INIT lasts NREGS cycles.
  - In INIT, wr_en and iss_en are ignored and rd_data returns 0.
  - RUN is terminal until the next reset.
- Reads: combinational, zero latency. rd_data[k] = regs[rd_addr[k]], or 0 when ZERO_REG=1 and the address is 0. Write-through on the same cycle is controlled by RF_BYPASS_EN (see below).
- Writes in RUN: committed on the rising edge.
  - Several ports writing the same address: the highest-index port wins.
  - With ZERO_REG=1, writes to address 0 are discarded.
- Scoreboard:
  - A write to address a clears pend[a].
  - iss_en sets pend[iss_addr].
  - iss_en and a write to the same address in the same cycle: the set wins; a new producer supersedes the old one.
  - pend[0] is never set when ZERO_REG=1.
  - rd_pend[k] = pend[rd_addr[k]].
  - pend_any is registered, reflects the post-edge state and has one cycle of latency versus pend.
- Arithmetic: no arithmetic on data; address compares are AW bits wide. Index wrap is not possible because the FSM exits at NREGS-1.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: in RUN, a read port whose address matches an active write this cycle returns that wr_data, using the same highest-index-port priority. rd_pend for that port also reflects the clear (0) unless iss_en targets the same address. Address 0 is still forced to 0 when ZERO_REG=1.
- Undefined: reads return the pre-edge array value, and a write is visible one cycle after wr_en.

Decomposition:
- Shared package rf_pkg:
  - default XLEN and NREGS;
  - FSM state enum (RF_INIT, RF_RUN);
  - a clog2 function for AW.
- One natural sub-module: rf_scoreboard. It holds the NREGS pend bits and the set/clear priority logic and drives pend_any.
- The array, FSM and read muxing stay in regfile_mp.

Test Plan:
1. Post-reset clear:
   - Stimulus: reset low 2 cycles, then high.
   - Expect init_busy=1 for exactly 32 cycles with defaults.
   - A write of 0xDEAD to x5 during INIT is ignored; after init, reading x5 returns 0.
2. Basic read/write and zero register:
   - Write x1=10 on port 0; next cycle read x1 gives 10.
   - Write x0=20 on port 1; reading x0 returns 0.
   - Write x1=15; reading x1 gives 15.
3. Write collision:
   - Port 0 writes x3=0x11 and port 1 writes x3=0x22 in the same cycle.
   - Reading x3 gives 0x22; no other register changes.
4. Scoreboard:
   - iss_en x4 → rd_pend=1 on a port addressing x4; pend_any=1 the next cycle.
   - Write x4=25 → pend clears.
   - iss_en x4 together with a write to x4 → pend stays 1.
   - iss_en x0 → pend stays 0.
5. Bypass:
   - Write x6=0x5A and read x6 on the same cycle.
   - RF_BYPASS_EN defined: read gives 0x5A that cycle.
   - Not defined: read gives the old value, then 0x5A the next cycle.
6. Mid-operation reset:
   - Assert reset mid-INIT (idx≈10) and again in RUN with pending bits set.
   - Expect init_busy=1 and pend_any=0 asynchronously.
   - Expect a full 32-cycle clear after deassert.
